// File: rtl/serial_frame_aligner.sv
// Byte-boundary aligner: hunts for SYNC in the deserialiser window, captures
// FRAME_LEN payload bytes per frame with flywheel tolerance, and queues them in a small FIFO.
module serial_frame_aligner #(
  parameter logic [7:0] SYNC       = 8'h47,
  parameter int         FRAME_LEN  = 4,
  parameter int         MISS_MAX   = 3,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  output logic [7:0] o_byte,
  output logic       o_first,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_locked,
  output logic       o_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [3:0]  miss_cnt_q, miss_cnt_d;
  logic        push, push_first;
  logic        sync_hit, sync_slot;

  logic [8:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0]  head_byte_q, head_byte_d;
  logic        head_first_q, head_first_d;
  logic        overflow_q, overflow_d;
  logic        empty, full, pop, push_ok;

  assign sync_hit  = (i_data == SYNC);
  assign sync_slot = (byte_cnt_q == 8'(FRAME_LEN));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= HUNT;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // The byte boundary is the edge on which bit_cnt wraps, eight edges after the sync match.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    miss_cnt_d = miss_cnt_q;
    push       = 1'b0;
    push_first = 1'b0;
    case (state_q)
      HUNT: begin
        if (sync_hit) begin
          state_d    = LOCKED;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          miss_cnt_d = '0;
        end
      end
      LOCKED: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (!sync_slot) begin
            push       = 1'b1;
            push_first = (byte_cnt_q == 8'd0);
            byte_cnt_d = byte_cnt_q + 8'd1;
          end else begin
            byte_cnt_d = '0;
            if (sync_hit) begin
              miss_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + 4'd1;
              if (miss_cnt_d == 4'(MISS_MAX)) state_d = HUNT;
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    o_locked = (state_q == LOCKED);
  end

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign pop     = !empty && i_ready;
  assign push_ok = push && (!full || pop);

  // Head registers look ahead at the post-edge FIFO so a push into an empty FIFO shows next cycle.
  always_comb begin
    wr_d         = wr_q + {{AW{1'b0}}, push_ok};
    rd_d         = rd_q + {{AW{1'b0}}, pop};
    overflow_d   = push && full && !pop;
    head_byte_d  = head_byte_q;
    head_first_d = head_first_q;
    if (wr_d != rd_d) begin
      if (push_ok && (rd_d[AW-1:0] == wr_q[AW-1:0])) begin
        {head_first_d, head_byte_d} = {push_first, i_data};
      end else begin
        {head_first_d, head_byte_d} = mem_q[rd_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= {push_first, i_data};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_q         <= '0;
      rd_q         <= '0;
      head_byte_q  <= '0;
      head_first_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      head_byte_q  <= head_byte_d;
      head_first_q <= head_first_d;
      overflow_q   <= overflow_d;
    end
  end

  assign o_byte     = head_byte_q;
  assign o_first    = head_first_q;
  assign o_valid    = !empty;
  assign o_overflow = overflow_q;
endmodule

// File: tb/tb_serial_frame_aligner.sv
// Bench for serial_frame_aligner: serial bit stream into an emulated shift register,
// checked against a frame-position reference model plus table and hand-written sequences.
module tb_serial_frame_aligner;
  localparam logic [7:0] SYNC = 8'h47;
  localparam int FRAME_LEN = 4;
  localparam int MISS_MAX  = 3;
  localparam int DEPTH     = 4;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic       i_ready = 1'b0;
  logic [7:0] o_byte;
  logic       o_first, o_valid, o_locked, o_overflow;

  serial_frame_aligner #(.SYNC(SYNC), .FRAME_LEN(FRAME_LEN), .MISS_MAX(MISS_MAX),
                         .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .o_byte(o_byte), .o_first(o_first),
    .o_valid(o_valid), .i_ready(i_ready), .o_locked(o_locked), .o_overflow(o_overflow));

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] data;
    logic       locked;
    logic       valid;
    logic [7:0] byt;
    logic       first;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int ovf_cnt = 0;
  int edge_n = 0;
  logic [7:0] window = 8'h00;

  // Reference model: frame position derived from edges elapsed since the sync match.
  logic       m_locked = 1'b0;
  int         m_lock_edge = 0;
  int         m_miss = 0;
  logic [8:0] mq[$];
  logic       m_ovf = 1'b0;
  logic [7:0] exp_drain [4];

  task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_miss = 0;
    m_ovf = 1'b0;
    mq.delete();
    window = 8'h00;
    i_data = 8'h00;
  endtask

  task automatic step(input logic b, input logic rdy);
    logic       pop, push;
    logic [8:0] ent;
    int         k, slot;
    window  = {window[6:0], b};
    i_data  = window;
    i_ready = rdy;
    push = 1'b0;
    ent  = '0;
    pop  = (mq.size() != 0) && rdy;
    if (!m_locked) begin
      if (window == SYNC) begin
        m_locked = 1'b1;
        m_lock_edge = edge_n;
        m_miss = 0;
      end
    end else begin
      k = edge_n - m_lock_edge;
      if (k % 8 == 0) begin
        slot = (k / 8 - 1) % (FRAME_LEN + 1);
        if (slot < FRAME_LEN) begin
          push = 1'b1;
          ent = {(slot == 0), window};
        end else if (window == SYNC) begin
          m_miss = 0;
        end else begin
          m_miss++;
          if (m_miss == MISS_MAX) m_locked = 1'b0;
        end
      end
    end
    m_ovf = push && (mq.size() == DEPTH) && !pop;
    if (pop) void'(mq.pop_front());
    if (push && !m_ovf) mq.push_back(ent);
    @(posedge i_clk);
    edge_n++;
    #1;
    if (o_overflow) ovf_cnt++;
    chk("model_locked", {8'h0, o_locked}, {8'h0, m_locked});
    chk("model_valid", {8'h0, o_valid}, {8'h0, (mq.size() != 0)});
    chk("model_overflow", {8'h0, o_overflow}, {8'h0, m_ovf});
    if (mq.size() != 0) begin
      chk("model_byte", {1'b0, o_byte}, {1'b0, mq[0][7:0]});
      chk("model_first", {8'h0, o_first}, {8'h0, mq[0][8]});
    end
  endtask

  task automatic send_byte(input logic [7:0] data, input logic [7:0] rdy_mask);
    for (int i = 7; i >= 0; i--) step(data[i], rdy_mask[i]);
  endtask

  task automatic drain_byte(input logic [7:0] data);
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        chk("drain_valid", {8'h0, o_valid}, 9'h1);
        chk("drain_byte", {1'b0, o_byte}, {1'b0, exp_drain[i]});
      end else if (i == 4) begin
        chk("drain_empty", {8'h0, o_valid}, 9'h0);
      end
      step(data[7-i], 1'b1);
    end
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_byte"}, {1'b0, o_byte}, 9'h0);
    chk({nm, "_first"}, {8'h0, o_first}, 9'h0);
    chk({nm, "_valid"}, {8'h0, o_valid}, 9'h0);
    chk({nm, "_locked"}, {8'h0, o_locked}, 9'h0);
    chk({nm, "_overflow"}, {8'h0, o_overflow}, 9'h0);
  endtask

  task automatic reset_pulse();
    i_rst = 1'b1;
    #2;
    check_all_zero("rst_mid");
    model_reset();
    i_rst = 1'b0;
    #1;
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic l, input logic v,
                              input logic [7:0] b, input logic f);
    vec_t r;
    r.data = d; r.locked = l; r.valid = v; r.byt = b; r.first = f;
    return r;
  endfunction

  vec_t tbl[$];
  logic [7:0] payload [4][4] = '{'{8'h10, 8'h20, 8'h30, 8'h40},
                                 '{8'h50, 8'h60, 8'h70, 8'h80},
                                 '{8'h91, 8'h92, 8'h93, 8'h94},
                                 '{8'hA1, 8'hA2, 8'hA3, 8'hA4}};
  logic [7:0] frame_sync [4] = '{8'h00, 8'h47, 8'h00, 8'h00};

  initial begin
    // Lock/stream, false sync in payload, flywheel and lock loss.
    tbl.push_back(mk(8'h47, 1, 0, 8'h00, 0));
    tbl.push_back(mk(8'h11, 1, 1, 8'h11, 1));
    tbl.push_back(mk(8'h22, 1, 1, 8'h22, 0));
    tbl.push_back(mk(8'h33, 1, 1, 8'h33, 0));
    tbl.push_back(mk(8'h44, 1, 1, 8'h44, 0));
    tbl.push_back(mk(8'h47, 1, 0, 8'h00, 0));
    tbl.push_back(mk(8'h47, 1, 1, 8'h47, 1));
    tbl.push_back(mk(8'hA5, 1, 1, 8'hA5, 0));
    tbl.push_back(mk(8'h01, 1, 1, 8'h01, 0));
    tbl.push_back(mk(8'h02, 1, 1, 8'h02, 0));
    tbl.push_back(mk(8'h47, 1, 0, 8'h00, 0));
    for (int f = 0; f < 4; f++) begin
      for (int j = 0; j < 4; j++) tbl.push_back(mk(payload[f][j], 1, 1, payload[f][j], (j == 0)));
      tbl.push_back(mk(frame_sync[f], 1, 0, 8'h00, 0));
    end
    for (int j = 0; j < 4; j++) tbl.push_back(mk(8'hB1 + 8'(j), 1, 1, 8'hB1 + 8'(j), (j == 0)));
    tbl.push_back(mk(8'h00, 0, 0, 8'h00, 0));
    tbl.push_back(mk(8'hB5, 0, 0, 8'h00, 0));

    #2;
    check_all_zero("reset");
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    send_byte(8'h47, 8'h00);
    send_byte(8'hD1, 8'h00);
    send_byte(8'hD2, 8'h00);
    chk("queued_valid", {8'h0, o_valid}, 9'h1);
    chk("queued_byte", {1'b0, o_byte}, 9'h0D1);
    reset_pulse();
    send_byte(8'h12, 8'hFF);
    chk("post_rst_unlocked", {8'h0, o_locked}, 9'h0);

    for (int n = 0; n < tbl.size(); n++) begin
      send_byte(tbl[n].data, 8'hFF);
      chk("tbl_locked", {8'h0, o_locked}, {8'h0, tbl[n].locked});
      chk("tbl_valid", {8'h0, o_valid}, {8'h0, tbl[n].valid});
      if (tbl[n].valid) begin
        chk("tbl_byte", {1'b0, o_byte}, {1'b0, tbl[n].byt});
        chk("tbl_first", {8'h0, o_first}, {8'h0, tbl[n].first});
      end
    end

    // Backpressure: six captures into a four-entry FIFO.
    send_byte(8'h47, 8'h00);
    chk("bp_relock", {8'h0, o_locked}, 9'h1);
    ovf_cnt = 0;
    send_byte(8'h11, 8'h00);
    send_byte(8'h22, 8'h00);
    send_byte(8'h33, 8'h00);
    send_byte(8'h44, 8'h00);
    send_byte(8'h47, 8'h00);
    send_byte(8'h55, 8'h00);
    send_byte(8'h66, 8'h00);
    chk("bp_overflow_pulses", 9'(ovf_cnt), 9'd2);
    exp_drain = '{8'h11, 8'h22, 8'h33, 8'h44};
    drain_byte(8'h77);

    // Full FIFO with a pop on the capture edge.
    send_byte(8'h88, 8'h00);
    send_byte(8'h47, 8'h00);
    send_byte(8'hC1, 8'h00);
    send_byte(8'hC2, 8'h00);
    chk("full_valid", {8'h0, o_valid}, 9'h1);
    ovf_cnt = 0;
    send_byte(8'hC3, 8'h01);
    chk("full_pop_no_ovf", {8'h0, o_overflow}, 9'h0);
    exp_drain = '{8'h88, 8'hC1, 8'hC2, 8'hC3};
    drain_byte(8'hC4);
    chk("full_pop_ovf_cnt", 9'(ovf_cnt), 9'd0);

    for (int n = 0; n < 400; n++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 2) == 0) ? SYNC : 8'($urandom);
      for (int i = 7; i >= 0; i--) step(d[i], ($urandom_range(0, 3) != 0));
      if (n == 200) reset_pulse();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
